// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: issues sequential fetches with one request outstanding, buffers
// {pc, instruction} pairs for decode, and handles branch/jump redirect with flush.
module instruction_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter int unsigned           PC_STEP     = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned           FIFO_DEPTH  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          imem_req,
   output logic [ADDR_WIDTH-1:0]         imem_addr,
   input  logic                          imem_rvalid,
   input  logic [INSTR_WIDTH-1:0]        imem_rdata,
   input  logic                          redirect_valid,
   input  logic [ADDR_WIDTH-1:0]         redirect_pc,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [INSTR_WIDTH-1:0]        instr_data,
   output logic [ADDR_WIDTH-1:0]         instr_pc,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned           PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned           CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));
   localparam logic [CNT_W-1:0]      DEPTH      = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StReq, StWait, StDiscard} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    stale_resp_q;
   logic [ADDR_WIDTH-1:0]   pc_mem_q   [FIFO_DEPTH];
   logic [INSTR_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];

   logic full;
   logic issue;
   logic push;
   logic pop;

   // Issue only with a free slot already in hand; a same-cycle pop does not count.
   // Gating with reset keeps the request low while reset is held.
   always_comb begin
      full  = (count_q == DEPTH);
      issue = (state_q == StReq) && !full && !redirect_valid && reset;
      push  = (state_q == StWait) && imem_rvalid && !redirect_valid;
      pop   = (count_q != '0) && instr_ready;
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StReq;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a redirect while waiting turns the outstanding response into a discard
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReq: begin
            if (issue) state_d = StWait;
         end
         StWait: begin
            if (imem_rvalid)         state_d = StReq;
            else if (redirect_valid) state_d = StDiscard;
         end
         StDiscard: begin
            if (imem_rvalid) state_d = StReq;
         end
         default: state_d = StReq;
      endcase
   end

   // FSM / datapath outputs
   always_comb begin
      imem_req    = issue;
      imem_addr   = issue ? fetch_pc_q : '0;
      instr_valid = (count_q != '0);
      instr_data  = data_mem_q[rd_ptr_q];
      instr_pc    = pc_mem_q[rd_ptr_q];
      fifo_count  = count_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + STEP;
      end
      if (issue) req_pc_d = fetch_pc_q;
   end

   // Redirect wins over any push/pop: the buffer is simply emptied.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (!push && pop) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
         data_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   // A response orphaned by reset may still land once; only that one is tolerated in REQ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stale_resp_q <= 1'b1;
      end else if (imem_rvalid) begin
         stale_resp_q <= 1'b0;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && full && !pop));

   a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (!reset)
      !(imem_rvalid && (state_q == StReq) && !stale_resp_q));

endmodule
